// File: rtl/op_framer_pkg.sv
// rtl/op_framer_pkg.sv - opcode constants, FSM state type and opcode helpers for op_framer
package op_framer_pkg;

   localparam logic [2:0] OP_READ = 3'b000;
   localparam logic [2:0] OP_POP  = 3'b001;
   localparam logic [2:0] OP_PUSH = 3'b101;

   // Shared counter width: covers TIMEOUT up to 255 and GAP up to 15.
   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_OPERAND,
      ISSUE,
      SPACING
   } state_t;

   // Only a push carries a second (operand) byte.
   function automatic logic has_operand(input logic [2:0] op);
      return (op == OP_PUSH);
   endfunction

endpackage

// File: rtl/op_framer_if.sv
// rtl/op_framer_if.sv - byte stream input and core command bus between source, op_framer and core
interface op_framer_if;

   logic [7:0] byte_in;
   logic       byte_valid;
   logic       byte_ready;
   logic [7:0] in;
   logic [2:0] op;
   logic       apply;
   logic       empty;
   logic       err;
   logic       busy;

   // Framer side: consumes the byte stream and the core's empty flag.
   modport master (
      input  byte_in, byte_valid, empty,
      output byte_ready, in, op, apply, err, busy
   );

   // Environment side: byte source plus the core.
   modport slave (
      output byte_in, byte_valid, empty,
      input  byte_ready, in, op, apply, err, busy
   );

endinterface

// File: rtl/op_framer_cnt.sv
// rtl/op_framer_cnt.sv - loadable up/down counter shared by operand timeout and apply spacing
module op_framer_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   input  logic         up_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Load has priority over counting; direction chosen by the owner of the count.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (en_i) begin
         count_d = up_i ? (count_q + W'(1)) : (count_q - W'(1));
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/op_framer.sv
// rtl/op_framer.sv - byte stream to core command framer; OP_FRAMER_GUARD_EN drops pops on an empty core
module op_framer
   import op_framer_pkg::*;
#(
   parameter int GAP     = 1,
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   op_framer_if.master bus
);

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SP_LOAD = CNT_W'((GAP > 0) ? (GAP - 1) : 0);

   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [7:0]       in_q, in_d;
   logic             ready_q;
   logic             cnt_load;
   logic [CNT_W-1:0] cnt_val;
   logic             cnt_en;
   logic             cnt_up;
   logic [CNT_W-1:0] cnt;
   logic             byte_ready_c;
   logic             apply_c;
   logic             err_c;
   logic             xfer;

   op_framer_cnt #(.W(CNT_W)) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cnt_load),
      .load_val_i (cnt_val),
      .en_i       (cnt_en),
      .up_i       (cnt_up),
      .count_o    (cnt)
   );

   // ready_q holds byte_ready low until the first clock after reset releases.
   assign byte_ready_c = ready_q && ((state_q == IDLE) || (state_q == WAIT_OPERAND));
   assign xfer         = bus.byte_valid && byte_ready_c;

   // Next state, latched command fields and counter control.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      in_d     = in_q;
      cnt_load = 1'b0;
      cnt_val  = '0;
      cnt_en   = 1'b0;
      cnt_up   = 1'b1;
      apply_c  = 1'b0;
      err_c    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (xfer) begin
               op_d = bus.byte_in[7:5];
               if (has_operand(bus.byte_in[7:5])) begin
                  state_d  = WAIT_OPERAND;
                  cnt_load = 1'b1;
                  cnt_val  = '0;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         WAIT_OPERAND: begin
            // A byte on the final wait cycle still wins over the timeout.
            if (xfer) begin
               in_d    = bus.byte_in;
               state_d = ISSUE;
            end else if (cnt == TO_LAST) begin
               err_c   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_en = 1'b1;
               cnt_up = 1'b1;
            end
         end
         ISSUE: begin
`ifdef OP_FRAMER_GUARD_EN
            if ((op_q == OP_POP) && bus.empty) begin
               err_c = 1'b1;
            end else begin
               apply_c = 1'b1;
            end
`else
            apply_c = 1'b1;
`endif
            if (GAP == 0) begin
               state_d = IDLE;
            end else begin
               state_d  = SPACING;
               cnt_load = 1'b1;
               cnt_val  = SP_LOAD;
            end
         end
         SPACING: begin
            if (cnt == '0) begin
               state_d = IDLE;
            end else begin
               cnt_en = 1'b1;
               cnt_up = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, command registers and post-reset ready enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= '0;
         in_q    <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         in_q    <= in_d;
         ready_q <= 1'b1;
      end
   end

`ifndef OP_FRAMER_GUARD_EN
   logic unused_empty;
   assign unused_empty = bus.empty;
`endif

   assign bus.byte_ready = byte_ready_c;
   assign bus.in         = in_q;
   assign bus.op         = op_q;
   assign bus.apply      = apply_c;
   assign bus.err        = err_c;
   assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_op_framer.sv
// tb/tb_op_framer.sv - self-checking bench for op_framer with a timeline reference model
module tb_op_framer;
   import op_framer_pkg::*;

   localparam int GAP     = 1;
   localparam int TIMEOUT = 16;
`ifdef OP_FRAMER_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   op_framer_if bif();

   op_framer #(.GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: command timeline in absolute cycle numbers.
   int         cyc = 0;
   bit         m_phase = 0;        // 1 = opcode seen, operand byte still owed
   int         m_ready_at = 0;     // first cycle bytes are accepted again
   int         m_issue_at = -100;  // cycle the last command is issued
   int         m_busy_end = -100;  // end (exclusive) of issue + spacing window
   int         m_wait_start = 0;   // first cycle of the operand wait
   logic [2:0] m_op = '0;
   logic [7:0] m_in = '0;
   bit         m_xfer = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // One cycle: drive inputs, compare DUT against the model, advance the model.
   task automatic step(input bit r, input bit v, input logic [7:0] b, input bit e);
      bit e_ready, e_apply, e_err, e_busy, to;
      @(negedge clk);
      rst            = r;
      bif.byte_valid = v;
      bif.byte_in    = b;
      bif.empty      = e;
      #1;
      if (r) begin
         e_ready = 0; e_apply = 0; e_err = 0; e_busy = 0;
         m_op = '0; m_in = '0; m_phase = 0; m_xfer = 0;
         m_ready_at = cyc + 2; m_issue_at = -100; m_busy_end = -100;
      end else begin
         e_ready = (cyc >= m_ready_at);
         m_xfer  = v && e_ready;
         to      = m_phase && !m_xfer && ((cyc - m_wait_start) == TIMEOUT - 1);
         e_apply = (cyc == m_issue_at);
         e_err   = to;
         if (e_apply && GUARD && (m_op == OP_POP) && e) begin
            e_apply = 0;
            e_err   = 1;
         end
         e_busy = m_phase || ((cyc >= m_issue_at) && (cyc < m_busy_end));
      end
      chk("byte_ready", bif.byte_ready, e_ready);
      chk("apply", bif.apply, e_apply);
      chk("err", bif.err, e_err);
      chk("busy", bif.busy, e_busy);
      chk("op", bif.op, m_op);
      chk("in", bif.in, m_in);
      if (!r) begin
         if (!m_phase && m_xfer) begin
            m_op = b[7:5];
            if (b[7:5] == 3'b101) begin
               m_phase      = 1;
               m_wait_start = cyc + 1;
            end else begin
               m_issue_at = cyc + 1;
               m_ready_at = cyc + 2 + GAP;
               m_busy_end = m_ready_at;
            end
         end else if (m_phase && m_xfer) begin
            m_in       = b;
            m_phase    = 0;
            m_issue_at = cyc + 1;
            m_ready_at = cyc + 2 + GAP;
            m_busy_end = m_ready_at;
         end else if (to) begin
            m_phase = 0;
         end
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0);
   endtask

   // Offer a byte until the model says it transferred; bounded.
   task automatic send(input logic [7:0] b, input bit e);
      int k;
      k = 0;
      do begin
         step(0, 1, b, e);
         k++;
      end while (!m_xfer && k < 50);
      if (!m_xfer) chk("send_bound", 32'd0, 32'd1);
   endtask

   int         apply_cyc[$];
   logic [7:0] q[$];
   bit         src_v;
   logic [7:0] src_b;
   int         quiet;
   int         r;

   initial begin
      bif.byte_valid = 0;
      bif.byte_in    = '0;
      bif.empty      = 0;

      // Reset state.
      step(1, 0, 8'h00, 0);
      step(1, 0, 8'h00, 0);
      chk("rst_ready", bif.byte_ready, 0);
      chk("rst_busy", bif.busy, 0);
      chk("rst_op", bif.op, 0);
      step(0, 0, 8'h00, 0);
      chk("post_rst_ready0", bif.byte_ready, 0);
      step(0, 0, 8'h00, 0);
      chk("post_rst_ready1", bif.byte_ready, 1);

      // Reset in the middle of an operand wait.
      send(8'hA0, 0);
      idle(2);
      chk("t1_busy_pre", bif.busy, 1);
      step(1, 0, 8'h00, 0);
      chk("t1_op", bif.op, 0);
      chk("t1_busy", bif.busy, 0);
      chk("t1_apply", bif.apply, 0);
      step(0, 0, 8'h00, 0);
      chk("t1_ready0", bif.byte_ready, 0);
      step(0, 0, 8'h00, 0);
      chk("t1_ready1", bif.byte_ready, 1);

      // Push 0x22.
      send(8'hA0, 0);
      send(8'h22, 0);
      step(0, 0, 8'h00, 0);
      chk("t2_apply", bif.apply, 1);
      chk("t2_op", bif.op, 3'b101);
      chk("t2_in", bif.in, 8'h22);
      idle(2);

      // Read after push 0x59 keeps the operand.
      send(8'hA0, 0);
      send(8'h59, 0);
      idle(3);
      send(8'h00, 0);
      step(0, 0, 8'h00, 0);
      chk("t6_apply", bif.apply, 1);
      chk("t6_op", bif.op, 3'b000);
      chk("t6_in", bif.in, 8'h59);
      idle(2);

      // Operand timeout.
      send(8'hA0, 0);
      for (int k = 1; k <= TIMEOUT; k++) begin
         step(0, 0, 8'h00, 0);
         chk("t4_err", bif.err, (k == TIMEOUT) ? 1 : 0);
         chk("t4_noapply", bif.apply, 0);
      end
      step(0, 0, 8'h00, 0);
      chk("t4_idle", bif.busy, 0);
      chk("t4_op", bif.op, 3'b101);
      chk("t4_in", bif.in, 8'h59);

      // Pop on an empty core.
      send(8'h20, 1);
      step(0, 0, 8'h00, 1);
      chk("t5_apply", bif.apply, GUARD ? 0 : 1);
      chk("t5_err", bif.err, GUARD ? 1 : 0);
      chk("t5_op", bif.op, 3'b001);
      idle(2);

      // Twelve pushes streamed with valid held high.
      for (int k = 0; k < 12; k++) begin
         q.push_back(8'hA0 | 8'(k));
         q.push_back(8'(8'h30 + k));
      end
      for (int k = 0; k < 200 && apply_cyc.size() < 12; k++) begin
         if (q.size() > 0) begin
            step(0, 1, q[0], 0);
            if (m_xfer) void'(q.pop_front());
         end else begin
            step(0, 0, 8'h00, 0);
         end
         if (bif.apply) apply_cyc.push_back(cyc);
      end
      chk("t3_count", apply_cyc.size(), 12);
      for (int k = 1; k < apply_cyc.size(); k++)
         chk("t3_spacing", apply_cyc[k] - apply_cyc[k-1], 3 + GAP);
      idle(3);

      // Randomized traffic.
      src_v = 0;
      src_b = '0;
      quiet = 0;
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 399) == 0) begin
            step(1, 0, 8'h00, 0);
            src_v = 0;
            continue;
         end
         if (!src_v || m_xfer) begin
            src_v = 0;
            if (quiet > 0) begin
               quiet--;
            end else if ($urandom_range(0, 59) == 0) begin
               quiet = $urandom_range(10, 25);
            end else if ($urandom_range(0, 9) < 7) begin
               src_v = 1;
               r = $urandom_range(0, 9);
               if (r < 4)      src_b = 8'hA0 | 8'($urandom_range(0, 31));
               else if (r < 6) src_b = 8'h20 | 8'($urandom_range(0, 31));
               else if (r < 7) src_b = 8'($urandom_range(0, 31));
               else            src_b = 8'($urandom_range(0, 255));
            end
         end
         step(0, src_v, src_b, 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
